// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the MIPS ALU control decoder.
// Revision 1.0
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_SLT   = 3'b101,
    ALUOP_XOR   = 3'b110,
    ALUOP_LUI   = 3'b111
  } aluop_t;

  typedef enum logic [3:0] {
    CTL_AND  = 4'b0000,
    CTL_OR   = 4'b0001,
    CTL_ADD  = 4'b0010,
    CTL_XOR  = 4'b0011,
    CTL_NOR  = 4'b0100,
    CTL_SLTU = 4'b0101,
    CTL_SUB  = 4'b0110,
    CTL_SLT  = 4'b0111,
    CTL_SLL  = 4'b1000,
    CTL_SRL  = 4'b1001,
    CTL_SRA  = 4'b1010,
    CTL_LUI  = 4'b1011,
    CTL_NOP  = 4'b1111
  } aluctl_t;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;

endpackage

`default_nettype wire

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: R-type funct field to ALU operation, with a valid flag.
// Revision 1.0
`default_nettype none

module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output aluctl_t    ctl,
  output logic       valid
);

  // Variable and immediate shifts share a code; the datapath picks the amount source.
  always_comb begin
    ctl   = CTL_NOP;
    valid = 1'b1;
    case (funct)
      FUNCT_ADD,  FUNCT_ADDU: ctl = CTL_ADD;
      FUNCT_SUB,  FUNCT_SUBU: ctl = CTL_SUB;
      FUNCT_AND:              ctl = CTL_AND;
      FUNCT_OR:               ctl = CTL_OR;
      FUNCT_XOR:              ctl = CTL_XOR;
      FUNCT_NOR:              ctl = CTL_NOR;
      FUNCT_SLT:              ctl = CTL_SLT;
      FUNCT_SLTU:             ctl = CTL_SLTU;
      FUNCT_SLL,  FUNCT_SLLV: ctl = CTL_SLL;
      FUNCT_SRL,  FUNCT_SRLV: ctl = CTL_SRL;
      FUNCT_SRA,  FUNCT_SRAV: ctl = CTL_SRA;
      default: begin
        ctl   = CTL_NOP;
        valid = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_control.sv
// alu_control: MIPS ALU control decoder with a sticky illegal-funct flag.
// Revision 1.0
`default_nettype none

module alu_control
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] funct,
  input  logic [2:0] aluop,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic       err_sticky
);

  aluctl_t dec_ctl;
  logic    dec_valid;
  aluctl_t ctl;

  alu_funct_decode u_funct_decode (
    .funct (funct),
    .ctl   (dec_ctl),
    .valid (dec_valid)
  );

  // funct only matters for R-type; every other opcode forces illegal low.
  always_comb begin
    ctl     = CTL_NOP;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: ctl = CTL_ADD;
      ALUOP_SUB: ctl = CTL_SUB;
      ALUOP_AND: ctl = CTL_AND;
      ALUOP_OR:  ctl = CTL_OR;
      ALUOP_SLT: ctl = CTL_SLT;
      ALUOP_XOR: ctl = CTL_XOR;
      ALUOP_LUI: ctl = CTL_LUI;
      ALUOP_RTYPE: begin
        ctl     = dec_valid ? dec_ctl : CTL_NOP;
        illegal = ~dec_valid;
      end
      default: begin
        ctl     = CTL_NOP;
        illegal = 1'b0;
      end
    endcase
  end

  assign alucontrol = ctl;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= err_sticky | illegal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_control.sv
// tb_alu_control: directed self-checking bench for alu_control.
`default_nettype none

module tb_alu_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] funct = 6'd0;
  logic [2:0] aluop = 3'd0;
  logic [3:0] alucontrol;
  logic       illegal;
  logic       err_sticky;

  int passed = 0;
  int total  = 0;
  logic exp_sticky = 1'b0;

  alu_control dut (
    .clk        (clk),
    .reset      (reset),
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Apply inputs 1 ns after negedge, check combinational outputs, then the flag after posedge.
  task automatic step(input string tag, input logic rst, input logic [2:0] a,
                      input logic [5:0] f, input logic [3:0] exp_ctl, input logic exp_ill);
    @(negedge clk);
    #1;
    reset = rst;
    aluop = a;
    funct = f;
    #1;
    chk({tag, "_ctl"}, alucontrol, exp_ctl);
    chk({tag, "_ill"}, {3'b0, illegal}, {3'b0, exp_ill});
    @(posedge clk);
    exp_sticky = rst ? 1'b0 : (exp_sticky | exp_ill);
    #1;
    chk({tag, "_sticky"}, {3'b0, err_sticky}, {3'b0, exp_sticky});
  endtask

  // Hand-written R-type table: funct and the ALU code it must select.
  logic [5:0] r_funct [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                               6'b100100, 6'b100101, 6'b100110, 6'b100111,
                               6'b101010, 6'b101011, 6'b000000, 6'b000100,
                               6'b000010, 6'b000110, 6'b000011, 6'b000111};
  logic [3:0] r_ctl   [16] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110,
                               4'b0000, 4'b0001, 4'b0011, 4'b0100,
                               4'b0111, 4'b0101, 4'b1000, 4'b1000,
                               4'b1001, 4'b1001, 4'b1010, 4'b1010};
  logic [3:0] i_ctl   [8]  = '{4'b0010, 4'b0110, 4'b1111, 4'b0000,
                               4'b0001, 4'b0111, 4'b0011, 4'b1011};

  function automatic logic [4:0] model(input logic [2:0] a, input logic [5:0] f);
    logic [4:0] r;
    if (a != 3'b010) return {1'b0, i_ctl[a]};
    r = {1'b1, 4'b1111};
    for (int k = 0; k < 16; k++)
      if (r_funct[k] == f) r = {1'b0, r_ctl[k]};
    return r;
  endfunction

  initial begin
    logic [4:0] m;
    step("reset", 1'b1, 3'b000, 6'b000000, 4'b0010, 1'b0);

    for (int a = 0; a < 8; a++) begin
      if (a != 2) step($sformatf("iop%0d", a), 1'b0, 3'(a), 6'($urandom_range(0, 63)), i_ctl[a], 1'b0);
    end

    for (int k = 0; k < 16; k++)
      step($sformatf("rtype_%b", r_funct[k]), 1'b0, 3'b010, r_funct[k], r_ctl[k], 1'b0);

    step("ori_badfunct", 1'b0, 3'b100, 6'b111111, 4'b0001, 1'b0);
    step("rtype_111111", 1'b0, 3'b010, 6'b111111, 4'b1111, 1'b1);
    for (int k = 0; k < 10; k++)
      step($sformatf("hold%0d", k), 1'b0, 3'b000, 6'b000000, 4'b0010, 1'b0);
    step("rtype_001000", 1'b0, 3'b010, 6'b001000, 4'b1111, 1'b1);
    step("reset_vs_illegal", 1'b1, 3'b010, 6'b111111, 4'b1111, 1'b1);

    for (int v = 0; v < 512; v++) begin
      m = model(3'(v & 7), 6'(v >> 3));
      step($sformatf("sweep_a%0d_f%0d", v & 7, v >> 3), 1'b0, 3'(v & 7), 6'(v >> 3), m[3:0], m[4]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
